alu_test_sequencer: RTL and testbench
=====================================

// Module: alu_test_sequencer
// PURPOSE
//   Self-checking stimulus controller for the N-bit adder/ALU datapath (A, B, S1/S0, Cin -> D, Cout).
//   - Sweeps every operand/select/carry combination into the datapath.
//   - Delays each vector tag by the datapath latency and compares the registered {Cout,D} against a golden result.
//   - Counts mismatches, captures the first failing vector, and reports busy/done.
//   - Replaces free-running per-cycle ERROR printing with a counted, sequenced checker.
// PARAMETERS
//   N     4   operand width; vector width VW = 2N+3, vector count 2^VW
//   LAT   2   active edges from vector drive to a valid result at myresult/goodresult (LAT >= 1)
//   ERRW  12  error counter width; counter saturates at 2^ERRW-1
// PORTS
//   CLK          in   1      clock; all state updates on negedge CLK
//   RST          in   1      asynchronous, active-low reset
//   start        in   1      run request; sampled only in IDLE or DONE
//   A            out  N      operand A to datapath
//   B            out  N      operand B to datapath
//   S            out  2      {S1,S0} select to datapath
//   Cin          out  1      carry-in to datapath
//   myresult     in   N+1    datapath result {Cout,D}
//   goodresult   in   N+1    golden result {Cout,D}, same latency as myresult
//   busy         out  1      high in RUN and DRAIN
//   done         out  1      high in DONE; level until restart or reset
//   err_flag     out  1      sticky: set on any mismatch in current run
//   err_cnt      out  ERRW   mismatch count, saturating
//   first_err_vec out VW     vector index of first mismatch; 0 if none
// BEHAVIOUR
//   - Reset (RST=0, async): state=IDLE; vec counter=0; delay line cleared; all outputs 0. Applies mid-run too, with no partial results kept.
//   - Vector packing: vec[VW-1:0] = {S[1:0], Cin, A[N-1:0], B[N-1:0]}. The outputs are the vec register decoded, so B varies fastest.
//   - FSM states:
//     - IDLE: on start=1, go to RUN. Clear err_cnt, err_flag and first_err_vec. Set vec=0 and push tag (valid=1, idx=0).
//     - RUN: on each edge, vec<=vec+1 and push (1, vec+1). When vec==2^VW-1, go to DRAIN and push valid=0. vec holds, with no wrap.
//     - DRAIN: push valid=0 for LAT edges, then go to DONE.
//     - DONE: done=1 and outputs hold. start=1 restarts exactly as from IDLE, and done drops on the same edge.
//   - start is ignored in RUN and DRAIN.
//   - Delay line: LAT-deep shift register of {valid, idx[VW-1:0]}.
//   - Tag pushed with vector v emerges at the edge LAT edges after v was driven.
//   - Compare: at an edge where the tail is valid and myresult != goodresult:
//     - err_cnt increments unless it is all-ones (saturate);
//     - err_flag <= 1;
//     - if err_flag was 0, first_err_vec <= tail idx.
//   - The compare uses the values present before that edge. It has priority-free coexistence with push/state updates in the same edge.
//   - Timing: count the start edge as edge 1. Vector v is driven after edge v+1 and checked at edge v+1+LAT.
//   - done rises after edge 2^VW+LAT. For N=4, LAT=2 this is edge 2050.
//   - The last compare (vector 2^VW-1) completes on the same edge the FSM enters DONE.
//   - X/Z on myresult counts as a mismatch (use case inequality in the compare).
// STRUCTURE
//   - Shared package: FSM state encoding (IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3) and the VW = 2*N+3 width function.
//   - Sub-module: vec_delay_line (params W=VW+1, DEPTH=LAT; CLK, RST, din, dout). Negedge shift, async active-low clear.
//   - Top holds the FSM, vec counter, drain counter (clog2(LAT+1) bits), compare and error registers.
// TESTING (N=4, LAT=2, ERRW=12 unless noted)
//   1. Clean sweep: bench DUT/golden are both ideal ALUs with 2-edge latency; pulse start.
//      Expect busy for 2049 edges, done after edge 2050, err_cnt=0, err_flag=0, first_err_vec=0.
//   2. Single fault: bench corrupts myresult only for vector 11'h155.
//      Expect err_cnt=1, err_flag=1, first_err_vec=11'h155.
//   3. Stuck-at: myresult[0] forced 0.
//      Expect err_cnt = number of vectors with golden bit0=1, and first_err_vec = lowest such index.
//   4. Reset mid-run: RST=0 at edge 1000 for one cycle.
//      Expect all outputs 0 immediately (async) and state IDLE. A new start gives a full clean run (2050 edges).
//   5. Start handling: start held high through RUN is ignored (done still at 2050).
//      start in DONE restarts: counters cleared, done low on that edge.
//   6. Saturation: ERRW=4, myresult = ~goodresult.
//      Expect err_cnt=15 (held), err_flag=1, first_err_vec=0.

Source files
------------

// File: rtl/alu_test_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_test_sequencer_pkg : shared state encoding and vector-width helper
// Revision: 1.0
// ---------------------------------------------------------------------------
package alu_test_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Vector is {S[1:0], Cin, A[N-1:0], B[N-1:0]}
    function automatic int vec_width(input int n);
        return 2 * n + 3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_test_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_test_sequencer_if : stimulus/result bus between sequencer and datapath
// Revision: 1.0
// ---------------------------------------------------------------------------
interface alu_test_sequencer_if #(
    parameter int N = 4
);
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [1:0]   S;
    logic         Cin;
    logic [N:0]   myresult;
    logic [N:0]   goodresult;

    modport master (output A, B, S, Cin, input myresult, goodresult);
    modport slave  (input A, B, S, Cin, output myresult, goodresult);
endinterface
`default_nettype wire

// File: rtl/alu_test_sequencer_vec_delay_line.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vec_delay_line : DEPTH-stage negedge shift register for vector tags
// Revision: 1.0
// ---------------------------------------------------------------------------
module vec_delay_line #(
    parameter int W     = 12,
    parameter int DEPTH = 2
) (
    input  wire logic         CLK,
    input  wire logic         RST,
    input  wire logic [W-1:0] din,
    output logic      [W-1:0] dout
);

    logic [W-1:0] r_sh [DEPTH];

    always_ff @(negedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) r_sh[i] <= '0;
        end else begin
            r_sh[0] <= din;
            for (int i = 1; i < DEPTH; i++) r_sh[i] <= r_sh[i-1];
        end
    end

    assign dout = r_sh[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/alu_test_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_test_sequencer : sweeps all ALU vectors and counts result mismatches
// Revision: 1.0
// ---------------------------------------------------------------------------
module alu_test_sequencer
    import alu_test_sequencer_pkg::*;
#(
    parameter int N    = 4,
    parameter int LAT  = 2,
    parameter int ERRW = 12
) (
    input  wire logic                      CLK,
    input  wire logic                      RST,
    input  wire logic                      start,
    alu_test_sequencer_if.master           dp,
    output logic                           busy,
    output logic                           done,
    output logic                           err_flag,
    output logic [ERRW-1:0]                err_cnt,
    output logic [vec_width(N)-1:0]        first_err_vec
);

    localparam int               c_VW         = vec_width(N);
    localparam logic [c_VW-1:0]  c_LAST_VEC   = '1;
    localparam int               c_DW         = $clog2(LAT + 1);
    localparam logic [c_DW-1:0]  c_DRAIN_LAST = c_DW'(LAT - 1);

    state_t              r_state;
    logic [c_VW-1:0]     r_vec;
    logic [c_DW-1:0]     r_drain;
    logic                r_busy;
    logic                r_done;
    logic                r_err_flag;
    logic [ERRW-1:0]     r_err_cnt;
    logic [c_VW-1:0]     r_first;

    logic [c_VW:0]       w_din;
    logic [c_VW:0]       w_tail;
    logic                w_start_ok;
    logic                w_mismatch;

    assign w_start_ok = start && (r_state == ST_IDLE || r_state == ST_DONE);
    // Case inequality so X/Z on the datapath result counts as a failure
    assign w_mismatch = w_tail[c_VW] && (dp.myresult !== dp.goodresult);

    always_comb begin
        w_din = '0;
        case (r_state)
            ST_IDLE, ST_DONE: if (start) w_din = {1'b1, {c_VW{1'b0}}};
            ST_RUN:           if (r_vec != c_LAST_VEC) w_din = {1'b1, c_VW'(r_vec + 1'b1)};
            default:          w_din = '0;
        endcase
    end

    vec_delay_line #(
        .W     (c_VW + 1),
        .DEPTH (LAT)
    ) u_delay (
        .CLK  (CLK),
        .RST  (RST),
        .din  (w_din),
        .dout (w_tail)
    );

    always_ff @(negedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
            r_vec   <= '0;
            r_drain <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_vec   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (r_vec == c_LAST_VEC) begin
                        // The transition edge is the first of the LAT empty pushes
                        if (LAT == 1) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_DRAIN;
                            r_drain <= c_DW'(1);
                        end
                    end else begin
                        r_vec <= r_vec + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (r_drain == c_DRAIN_LAST) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_drain <= r_drain + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(negedge CLK or negedge RST) begin
        if (!RST) begin
            r_err_flag <= 1'b0;
            r_err_cnt  <= '0;
            r_first    <= '0;
        end else if (w_start_ok) begin
            r_err_flag <= 1'b0;
            r_err_cnt  <= '0;
            r_first    <= '0;
        end else if (w_mismatch) begin
            if (r_err_cnt != {ERRW{1'b1}}) r_err_cnt <= r_err_cnt + 1'b1;
            r_err_flag <= 1'b1;
            if (!r_err_flag) r_first <= w_tail[c_VW-1:0];
        end
    end

    assign dp.B          = r_vec[N-1:0];
    assign dp.A          = r_vec[2*N-1:N];
    assign dp.Cin        = r_vec[2*N];
    assign dp.S          = r_vec[c_VW-1:c_VW-2];
    assign busy          = r_busy;
    assign done          = r_done;
    assign err_flag      = r_err_flag;
    assign err_cnt       = r_err_cnt;
    assign first_err_vec = r_first;

endmodule
`default_nettype wire

// File: tb/tb_alu_test_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_test_sequencer : directed bench with a one-register ideal ALU model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_alu_test_sequencer;

    logic CLK   = 1'b0;
    logic RST   = 1'b0;
    logic start = 1'b0;

    logic        busy, done, err_flag;
    logic [11:0] err_cnt;
    logic [10:0] first_err_vec;
    logic        s_busy, s_done, s_err_flag;
    logic [3:0]  s_err_cnt;
    logic [10:0] s_first_err_vec;

    // 0 clean, 1 single fault at 11'h155, 2 stuck-at-0 on bit0
    int          fault_mode = 0;
    logic [4:0]  r_my    = '0;
    logic [4:0]  r_gold  = '0;
    logic [4:0]  r_smy   = '0;
    logic [4:0]  r_sgold = '0;

    int n_checks = 0;
    int n_errs   = 0;

    alu_test_sequencer_if #(.N(4)) dp_if ();
    alu_test_sequencer_if #(.N(4)) dp_sat ();

    alu_test_sequencer #(.N(4), .LAT(2), .ERRW(12)) dut (
        .CLK(CLK), .RST(RST), .start(start), .dp(dp_if.master),
        .busy(busy), .done(done), .err_flag(err_flag),
        .err_cnt(err_cnt), .first_err_vec(first_err_vec)
    );

    alu_test_sequencer #(.N(4), .LAT(2), .ERRW(4)) dut_sat (
        .CLK(CLK), .RST(RST), .start(start), .dp(dp_sat.master),
        .busy(s_busy), .done(s_done), .err_flag(s_err_flag),
        .err_cnt(s_err_cnt), .first_err_vec(s_first_err_vec)
    );

    always #5 CLK = ~CLK;

    function automatic logic [4:0] alu_ref(input logic [1:0] s, input logic c,
                                           input logic [3:0] a, input logic [3:0] b);
        case (s)
            2'd0:    return {1'b0, a} + {1'b0, b} + 5'(c);
            2'd1:    return {1'b0, a} + {1'b0, ~b} + 5'(c);
            2'd2:    return {1'b0, a & b};
            default: return {1'b0, a ^ b};
        endcase
    endfunction

    wire [10:0] w_vec = {dp_if.S, dp_if.Cin, dp_if.A, dp_if.B};
    wire [4:0]  w_ref = alu_ref(dp_if.S, dp_if.Cin, dp_if.A, dp_if.B);
    wire [4:0]  w_sref = alu_ref(dp_sat.S, dp_sat.Cin, dp_sat.A, dp_sat.B);

    // Datapath: one result register after the sequencer's vector register
    always @(negedge CLK) begin
        r_gold  <= w_ref;
        r_sgold <= w_sref;
        r_smy   <= ~w_sref;
        case (fault_mode)
            1:       r_my <= (w_vec == 11'h155) ? (w_ref ^ 5'h10) : w_ref;
            2:       r_my <= w_ref & 5'h1E;
            default: r_my <= w_ref;
        endcase
    end

    assign dp_if.myresult    = r_my;
    assign dp_if.goodresult  = r_gold;
    assign dp_sat.myresult   = r_smy;
    assign dp_sat.goodresult = r_sgold;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int          r1_busy, r1_done, r1_flag;
    logic [31:0] r1_cnt, r1_first, r1_vec;

    // Counts edges from the start edge (edge 1) until done is observed
    task automatic do_run(input bit hold_start, output int done_edge, output int busy_edges);
        done_edge  = -1;
        busy_edges = 0;
        @(posedge CLK);
        start = 1'b1;
        for (int e = 1; e <= 3000; e++) begin
            @(negedge CLK);
            @(posedge CLK);
            if (!hold_start) start = 1'b0;
            if (e == 1) begin
                r1_busy = int'(busy); r1_done = int'(done); r1_flag = int'(err_flag);
                r1_cnt = 32'(err_cnt); r1_first = 32'(first_err_vec); r1_vec = 32'(w_vec);
            end
            if (busy) busy_edges++;
            if (done) begin
                done_edge = e;
                break;
            end
        end
        start = 1'b0;
    endtask

    int de, be;

    initial begin
        // Reset state
        repeat (3) @(posedge CLK);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_errcnt", 32'(err_cnt), 0);
        check_eq("rst_vec", 32'(w_vec), 0);
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        check_eq("idle_busy", 32'(busy), 0);

        // 1. Clean sweep (saturation DUT runs alongside)
        fault_mode = 0;
        do_run(1'b0, de, be);
        check_eq("clean_done_edge", 32'(de), 2050);
        check_eq("clean_busy_edges", 32'(be), 2049);
        check_eq("clean_errcnt", 32'(err_cnt), 0);
        check_eq("clean_flag", 32'(err_flag), 0);
        check_eq("clean_first", 32'(first_err_vec), 0);
        check_eq("done_vec_hold", 32'(w_vec), 32'h7FF);
        check_eq("sat_done", 32'(s_done), 1);
        check_eq("sat_errcnt", 32'(s_err_cnt), 15);
        check_eq("sat_flag", 32'(s_err_flag), 1);
        check_eq("sat_first", 32'(s_first_err_vec), 0);

        // 2. Single fault on vector 11'h155
        fault_mode = 1;
        do_run(1'b0, de, be);
        check_eq("single_done_edge", 32'(de), 2050);
        check_eq("single_errcnt", 32'(err_cnt), 1);
        check_eq("single_flag", 32'(err_flag), 1);
        check_eq("single_first", 32'(first_err_vec), 32'h155);

        // 3. Stuck-at-0 on bit0: 256+256+128+256 vectors have golden bit0=1
        fault_mode = 2;
        do_run(1'b0, de, be);
        check_eq("stuck_errcnt", 32'(err_cnt), 896);
        check_eq("stuck_flag", 32'(err_flag), 1);
        check_eq("stuck_first", 32'(first_err_vec), 1);

        // 5b. Restart from DONE clears counters on the start edge
        fault_mode = 0;
        do_run(1'b0, de, be);
        check_eq("restart_done_low", 32'(r1_done), 0);
        check_eq("restart_busy", 32'(r1_busy), 1);
        check_eq("restart_cnt_clr", r1_cnt, 0);
        check_eq("restart_flag_clr", 32'(r1_flag), 0);
        check_eq("restart_first_clr", r1_first, 0);
        check_eq("restart_vec0", r1_vec, 0);
        check_eq("restart_done_edge", 32'(de), 2050);
        check_eq("restart_errcnt", 32'(err_cnt), 0);

        // 5a. start held high through RUN is ignored
        do_run(1'b1, de, be);
        check_eq("hold_done_edge", 32'(de), 2050);
        check_eq("hold_busy_edges", 32'(be), 2049);

        // 4. Reset mid-run, with a fault already counted
        fault_mode = 1;
        @(posedge CLK);
        start = 1'b1;
        for (int e = 1; e <= 999; e++) begin
            @(negedge CLK);
            @(posedge CLK);
            start = 1'b0;
        end
        check_eq("mid_vec", 32'(w_vec), 998);
        check_eq("mid_errcnt", 32'(err_cnt), 1);
        check_eq("mid_busy", 32'(busy), 1);
        RST = 1'b0;
        #1;
        check_eq("arst_busy", 32'(busy), 0);
        check_eq("arst_errcnt", 32'(err_cnt), 0);
        check_eq("arst_flag", 32'(err_flag), 0);
        check_eq("arst_first", 32'(first_err_vec), 0);
        check_eq("arst_vec", 32'(w_vec), 0);
        @(posedge CLK);
        RST = 1'b1;
        repeat (5) @(posedge CLK);
        check_eq("post_rst_busy", 32'(busy), 0);
        check_eq("post_rst_done", 32'(done), 0);
        fault_mode = 0;
        do_run(1'b0, de, be);
        check_eq("rerun_done_edge", 32'(de), 2050);
        check_eq("rerun_errcnt", 32'(err_cnt), 0);
        check_eq("rerun_flag", 32'(err_flag), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
